dcache_assoc: RTL
=================

DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter SETS, default 16, number of sets; must be a power of two, at least 2.
REQ-003 SHALL have parameter LINE_W, default 256, line width in bits; must equal the memory bus width.
REQ-004 SHALL have parameter WORD_W, default 32, CPU word width in bits.
REQ-005 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port p1_addr_i  input  32  CPU byte address.
REQ-008 SHALL have port p1_data_i  input  WORD_W  CPU store data.
REQ-009 SHALL have port p1_MemRead_i  input  1  load request.
REQ-010 SHALL have port p1_MemWrite_i  input  1  store request.
REQ-011 SHALL have port p1_data_o  output  WORD_W  load data.
REQ-012 SHALL have port p1_stall_o  output  1  CPU pipeline stall.
REQ-013 SHALL have port mem_data_i  input  LINE_W  refill line from memory.
REQ-014 SHALL have port mem_ack_i  input  1  memory transfer complete.
REQ-015 SHALL have port mem_data_o  output  LINE_W  write-back line.
REQ-016 SHALL have port mem_addr_o  output  32  line-aligned memory address.
REQ-017 SHALL have port mem_enable_o  output  1  memory request valid.
REQ-018 SHALL have port mem_write_o  output  1  1 = write-back, 0 = refill.

Function
REQ-019 SHALL split the address as follows: offset = log2(LINE_W/8) low bits; word select = the offset bits above bit 1; index = the next log2(SETS) bits; tag = the remaining upper bits.
REQ-020 SHALL keep per way/set: valid, dirty, tag, line, and an age of log2(WAYS) bits (no age when WAYS = 1).
REQ-021 SHALL, on a hit in IDLE, behave as follows.
- Load: p1_data_o shows the selected word combinationally in the same cycle, with p1_stall_o = 0.
- Store: the word is written at the clock edge and dirty is set.
REQ-022 SHALL drive p1_data_o = 0 whenever no load hit is presented.
REQ-023 SHALL, on a miss in IDLE, drive p1_stall_o = 1 combinationally in the same cycle and latch the victim way.
- Victim is the lowest-numbered invalid way; otherwise the way with age = WAYS-1.
REQ-024 SHALL implement FSM states IDLE, WRITEBACK, REFILL and REFILL_DONE.
- IDLE to WRITEBACK on a miss with a dirty victim; IDLE to REFILL otherwise.
- WRITEBACK to REFILL on mem_ack_i = 1.
- REFILL to REFILL_DONE on mem_ack_i = 1.
- REFILL_DONE to IDLE unconditionally; the request then completes as a hit.
REQ-025 SHALL, in WRITEBACK, drive mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, zero offset} and mem_data_o = victim line.
REQ-026 SHALL, in REFILL, drive mem_enable_o = 1, mem_write_o = 0 and mem_addr_o = {request tag, index, zero offset}.
- On ack: line = mem_data_i, tag written, valid = 1, dirty = 0.
REQ-027 SHALL hold mem_enable_o, mem_write_o, mem_addr_o and mem_data_o stable until mem_ack_i is sampled high, for any ack latency of 1 cycle or more.
- mem_ack_i is ignored outside WRITEBACK and REFILL.
REQ-028 SHALL keep p1_stall_o = 1 in WRITEBACK, REFILL and REFILL_DONE.
REQ-029 SHALL update ages on every hit and every refill:
- the accessed way's age becomes 0;
- ways with a smaller prior age increment by 1;
- all other ways are unchanged.
REQ-030 SHALL treat both p1_MemRead_i and p1_MemWrite_i high as a store.
REQ-031 SHALL hold no request state when neither p1_MemRead_i nor p1_MemWrite_i is high; it produces no stall.
REQ-032 SHALL rely on the CPU holding address, data and request stable while p1_stall_o = 1.

Reset
REQ-033 SHALL, while rst_i is high at a clock edge, set FSM = IDLE, all valid = 0, all dirty = 0, and age of way w = w.
- Outputs are then p1_stall_o = 0, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
REQ-034 SHALL abort an in-flight write-back or refill on reset (dirty data is discarded); mem_enable_o is low in the cycle after reset.

Structure
REQ-035 SHALL place the FSM state enum, the address-field width functions and the default parameter constants in a shared package, dcache_pkg.
REQ-036 SHALL use one sub-module, dcache_lru, which holds per-set ages, performs victim selection and performs the age update.

Verification
REQ-037 SHALL cover a cold load miss: WAYS = 2, SETS = 16, load 0x0000_0040.
- Required: stall = 1, mem_enable_o = 1, mem_write_o = 0, mem_addr_o = 0x40.
- Ack after 10 cycles with word0 = 0x1234_5678; then p1_data_o = 0x1234_5678 with stall = 0.
REQ-038 SHALL cover a load hit: load 0x44 after REQ-037.
- Required: stall = 0 in the same cycle, mem_enable_o stays 0, word1 is returned.
REQ-039 SHALL cover LRU dirty eviction.
- Stimulus: store 0xDEAD_BEEF to 0x40, load 0x240, then load 0x440 (all index 2).
- Required: write-back to address 0x40 with word0 = 0xDEAD_BEEF, then refill of 0x440; line 0x240 is retained.
REQ-040 SHALL cover ack delayed 50 cycles.
- Required: stall and all mem_* outputs stay constant for the 50 cycles; single transfer only.
REQ-041 SHALL cover reset asserted in the 3rd cycle of WRITEBACK.
- Required: next cycle mem_enable_o = 0 and stall = 0; a subsequent load of 0x40 misses.
REQ-042 SHALL cover direct-mapped operation: WAYS = 1, alternating loads of 0x40 and 0x240.
- Required: every access misses, with no write-back issued.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared FSM type, default parameters and address-field widths for dcache_assoc
package dcache_pkg;

    localparam int DEF_WAYS   = 2;
    localparam int DEF_SETS   = 16;
    localparam int DEF_LINE_W = 256;
    localparam int DEF_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WRITEBACK   = 2'd1,
        ST_REFILL      = 2'd2,
        ST_REFILL_DONE = 2'd3
    } state_t;

    function automatic int off_bits(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int line_w, input int sets);
        return 32 - off_bits(line_w) - idx_bits(sets);
    endfunction

    // A direct-mapped cache still needs a 1-bit way handle for port widths.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// rtl/dcache_lru.sv - per-set age tracking, victim selection and age update
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int WAYS = DEF_WAYS,
    parameter int SETS = DEF_SETS,
    localparam int WB  = way_bits(WAYS),
    localparam int IB  = idx_bits(SETS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IB-1:0]   idx,
    input  logic [WAYS-1:0] valid_vec,
    output logic [WB-1:0]   victim,
    input  logic            upd_en,
    input  logic [WB-1:0]   upd_way
);

    logic [WB-1:0] age_q [SETS][WAYS];
    logic          found;

    // Lowest invalid way wins; otherwise the oldest way (age WAYS-1).
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_vec[w] && !found) begin
                victim = WB'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == WB'(WAYS - 1)) victim = WB'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WB'(w);
        end else if (upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WB'(w) == upd_way)
                    age_q[idx][w] <= '0;
                else if (age_q[idx][w] < age_q[idx][upd_way])
                    age_q[idx][w] <= age_q[idx][w] + WB'(1);
            end
        end
    end

endmodule

// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - set-associative write-back data cache with blocking miss handling
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int WAYS   = DEF_WAYS,
    parameter int SETS   = DEF_SETS,
    parameter int LINE_W = DEF_LINE_W,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [31:0]       mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int OB = off_bits(LINE_W);
    localparam int IB = idx_bits(SETS);
    localparam int TB = tag_bits(LINE_W, SETS);
    localparam int WB = way_bits(WAYS);

    state_t            state_q, state_d;
    logic [SETS-1:0]   valid_q [WAYS];
    logic [SETS-1:0]   dirty_q [WAYS];
    logic [TB-1:0]     tag_q   [WAYS][SETS];
    logic [LINE_W-1:0] line_q  [WAYS][SETS];
    logic [WB-1:0]     victim_q, victim, hit_way, upd_way;
    logic [WAYS-1:0]   valid_vec;
    logic              req, hit, upd_en;
    logic [IB-1:0]     idx;
    logic [TB-1:0]     req_tag;
    logic [OB-1:0]     word_off;

    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign idx      = p1_addr_i[OB +: IB];
    assign req_tag  = p1_addr_i[31 -: TB];
    assign word_off = p1_addr_i[OB-1:0] >> 2;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            valid_vec[w] = valid_q[w][idx];
            if (valid_q[w][idx] && tag_q[w][idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        end
    end

    // Ages move on every hit and on the refill that installs the victim.
    assign upd_en  = (state_q == ST_IDLE && req && hit) || (state_q == ST_REFILL && mem_ack_i);
    assign upd_way = (state_q == ST_REFILL) ? victim_q : hit_way;

    dcache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .clk       (clk_i),
        .rst       (rst_i),
        .idx       (idx),
        .valid_vec (valid_vec),
        .victim    (victim),
        .upd_en    (upd_en),
        .upd_way   (upd_way)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (req && !hit)
                    state_d = (valid_vec[victim] && dirty_q[victim][idx]) ? ST_WRITEBACK : ST_REFILL;
            ST_WRITEBACK:   if (mem_ack_i) state_d = ST_REFILL;
            ST_REFILL:      if (mem_ack_i) state_d = ST_REFILL_DONE;
            ST_REFILL_DONE: state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        p1_stall_o   = 1'b0;
        p1_data_o    = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            ST_IDLE: begin
                if (req && !hit)
                    p1_stall_o = 1'b1;
                else if (req && !p1_MemWrite_i)
                    p1_data_o = line_q[hit_way][idx][word_off*WORD_W +: WORD_W];
            end
            ST_WRITEBACK: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[victim_q][idx], idx, {OB{1'b0}}};
                mem_data_o   = line_q[victim_q][idx];
            end
            ST_REFILL: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, idx, {OB{1'b0}}};
            end
            default: p1_stall_o = 1'b1;
        endcase
    end

    // Line and tag storage need no reset: valid gates every use of them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            if (state_q == ST_IDLE && req && !hit)
                victim_q <= victim;
            if (state_q == ST_IDLE && req && hit && p1_MemWrite_i) begin
                line_q[hit_way][idx][word_off*WORD_W +: WORD_W] <= p1_data_i;
                dirty_q[hit_way][idx] <= 1'b1;
            end
            if (state_q == ST_REFILL && mem_ack_i) begin
                line_q[victim_q][idx]  <= mem_data_i;
                tag_q[victim_q][idx]   <= req_tag;
                valid_q[victim_q][idx] <= 1'b1;
                dirty_q[victim_q][idx] <= 1'b0;
            end
        end
    end

endmodule
